wb_arbiter: RTL and testbench
=============================

Name: wb_arbiter

Overview:
- Shares the single register-file write/unlock port (wr_addr/wr_data/wr_en) between NUM_WB write-back requesters, such as the ALU, LSU, FPU and MUL/DIV units.
- Uses round-robin arbitration over valid/ready handshakes.
- Registers the winning write, so the register file sees a clean, glitch-free write port one cycle after acceptance.
- Sits between the execution units and the lock-based register file. The same cycle that commits a write also clears that register's lock.

Parameters:
- NUM_WB, 4, number of write-back requesters; legal range 2..8.
- MAXLEN, 64, write data width; equals max(XLEN, FLEN) of the register file.

Ports:
- clk_i  in  1  clock, rising edge.
- arst_ni  in  1  reset, asynchronous, active-low.
- wb_valid_i  in  NUM_WB  requester i has a write pending.
- wb_addr_i  in  NUM_WB x 6  destination address; bit 5 = FP file, bits 4:0 = index.
- wb_data_i  in  NUM_WB x MAXLEN  write data.
- wb_ready_o  out  NUM_WB  requester i accepted this cycle (one-hot or zero).
- hold_i  in  1  freeze: no grants while high (debug halt / flush).
- wr_addr_o  out  6  to register file wr_addr_i.
- wr_data_o  out  MAXLEN  to register file wr_data_i.
- wr_en_o  out  1  to register file wr_en_i.
- busy_o  out  1  any wb_valid_i high, or wr_en_o high.

Behaviour:
- Reset values:
  - wr_en_o = 0, wr_addr_o = 0, wr_data_o = 0.
  - Round-robin pointer ptr_q = 0.
  - wb_ready_o = 0 while reset is asserted.
- Arbitration (combinational):
  - Scan wb_valid_i starting at index ptr_q, ascending with wrap.
  - The first valid index wins: gnt[i] = 1. At most one grant per cycle.
  - hold_i = 1 forces gnt = 0.
  - wb_ready_o = gnt. A requester may drop valid only after a cycle with ready = 1.
  - ready depends on valid; valid must not depend on ready.
- Pointer update:
  - On any grant to i, ptr_q <= (i+1) mod NUM_WB.
  - With no grant, ptr_q holds.
  - Guarantees each continuously valid requester is granted within NUM_WB cycles.
- Output stage (registered; latency 1 cycle accept -> wr_en_o):
  - wr_en_o <= |gnt.
  - If |gnt: wr_addr_o <= wb_addr_i[i], wr_data_o <= wb_data_i[i].
  - Otherwise addr/data hold their previous value and wr_en_o = 0.
  - The register-file write port always accepts, so there is no backpressure into the output stage and full throughput is 1 write/cycle.
- Address 0 (x0) writes are passed through unchanged; the register file discards them.
- Two requesters targeting the same address are serialised in grant order. The later write overwrites; there is no merge or reorder.
- hold_i:
  - Takes effect in the same cycle.
  - A write already registered still completes (wr_en_o pulses once).
  - Requesters keep valid asserted and are served after release, starting from the unchanged ptr_q.
- Reset mid-operation: the pending output write is dropped, wr_en_o = 0 immediately (async), and ptr_q = 0.
- No X propagation: unselected data lanes are ignored.
- Assertions:
  - wb_ready_o is one-hot-or-zero.
  - ready implies valid.
  - A valid with stable addr/data is never dropped before ready.

Decomposition:
- Shared package wb_pkg:
  - wb_req_t struct {addr[5:0], data[MAXLEN-1:0]}.
  - Constant WB_ADDR_W = 6.
  - Requester index enum: WB_ALU = 0, WB_LSU = 1, WB_FPU = 2, WB_MDU = 3.
- Sub-module rr_arbiter #(N):
  - Inputs: req, en, ptr.
  - Outputs: gnt (one-hot), gnt_idx, any.
  - Pure combinational rotate-priority encoder, reusable for the issue/dispatch scheduler.
- wb_arbiter holds ptr_q, the output register and the muxing.

Test Plan:
- Reset and idle: arst_ni low, then high with all valid = 0 -> wr_en_o = 0, wb_ready_o = 0, busy_o = 0 for 10 cycles.
- Single write: valid[2] = 1, addr = 6'h25, data = 64'hDEAD_BEEF for 1 cycle:
  - ready[2] = 1 in the same cycle.
  - Next cycle: wr_en_o = 1, wr_addr_o = 6'h25, wr_data_o = 64'hDEAD_BEEF.
  - ptr_q = 3.
- Round-robin fairness: all 4 valid continuously with ptr_q = 0 -> grants 0, 1, 2, 3, 0, ... one per cycle; wr_en_o high every cycle after the first.
- Same-address ordering: req 1 (addr 6'h05, data 1) and req 3 (addr 6'h05, data 3) both valid, ptr_q = 2:
  - Req 3 is written first, then req 1.
  - The register file holds 1 afterwards.
- Hold: valid[0] = 1 with hold_i = 1 for 5 cycles:
  - ready[0] = 0 and wr_en_o = 0 throughout.
  - hold_i low -> ready[0] = 1, and wr_en_o = 1 the next cycle.
- Reset mid-write: grant issued at cycle N, arst_ni low at N+0.5 -> wr_en_o = 0 asynchronously and ptr_q = 0; no write reaches the register file.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared write-back definitions: request record, address width and requester indices.
// Imported by the arbiter, its interface and anything that drives the write-back bus.
package wb_pkg;

    localparam int WB_ADDR_W = 6;
    localparam int WB_MAXLEN = 64;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_MAXLEN-1:0] data;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_LSU = 2'd1,
        WB_FPU = 2'd2,
        WB_MDU = 2'd3
    } wb_src_e;

    // Next round-robin start position after index idx out of n lanes.
    function automatic int unsigned wrap_inc(int unsigned idx, int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back bus between execution units and the arbiter, plus the register-file write port.
interface wb_arbiter_if #(
    parameter int NUM_WB = 4,
    parameter int MAXLEN = 64
);
    import wb_pkg::*;

    logic [NUM_WB-1:0]                wb_valid_i;
    logic [NUM_WB-1:0][WB_ADDR_W-1:0] wb_addr_i;
    logic [NUM_WB-1:0][MAXLEN-1:0]    wb_data_i;
    logic [NUM_WB-1:0]                wb_ready_o;
    logic                             hold_i;
    logic [WB_ADDR_W-1:0]             wr_addr_o;
    logic [MAXLEN-1:0]                wr_data_o;
    logic                             wr_en_o;
    logic                             busy_o;

    modport slave (
        input  wb_valid_i, wb_addr_i, wb_data_i, hold_i,
        output wb_ready_o, wr_addr_o, wr_data_o, wr_en_o, busy_o
    );

    modport master (
        output wb_valid_i, wb_addr_i, wb_data_i, hold_i,
        input  wb_ready_o, wr_addr_o, wr_data_o, wr_en_o, busy_o
    );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Combinational rotate-priority encoder: first asserted req at or after ptr wins.
// Kept generic so the issue/dispatch scheduler can reuse it.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic          en,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    int            idx;
    logic [IW-1:0] idx_w;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        idx     = 0;
        idx_w   = '0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            idx_w = IW'(idx);
            if (en && !any && req[idx_w]) begin
                gnt[idx_w] = 1'b1;
                gnt_idx    = idx_w;
                any        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between NUM_WB write-back units.
// The winning write is registered so the register file sees a clean port one cycle later.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int NUM_WB = 4,
    parameter int MAXLEN = 64
) (
    input logic         clk_i,
    input logic         arst_ni,
    wb_arbiter_if.slave bus
);

    localparam int IW = $clog2(NUM_WB);

    logic [IW-1:0]        ptr_q;
    logic [NUM_WB-1:0]    gnt;
    logic [IW-1:0]        gnt_idx;
    logic                 gnt_any;
    logic                 arb_en;
    logic                 wr_en_q;
    logic [WB_ADDR_W-1:0] wr_addr_q;
    logic [MAXLEN-1:0]    wr_data_q;

    // No grants during hold or while reset is asserted.
    assign arb_en = arst_ni & ~bus.hold_i;

    rr_arbiter #(.N(NUM_WB)) u_rr (
        .req     (bus.wb_valid_i),
        .en      (arb_en),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (gnt_any)
    );

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ptr_q <= '0;
        end else if (gnt_any) begin
            ptr_q <= IW'(wrap_inc(32'(gnt_idx), NUM_WB));
        end
    end

    // Only the granted lane is muxed, so idle lanes carrying X never reach the port.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_en_q <= gnt_any;
            if (gnt_any) begin
                wr_addr_q <= bus.wb_addr_i[gnt_idx];
                wr_data_q <= bus.wb_data_i[gnt_idx];
            end
        end
    end

    assign bus.wb_ready_o = gnt;
    assign bus.wr_en_o    = wr_en_q;
    assign bus.wr_addr_o  = wr_addr_q;
    assign bus.wr_data_o  = wr_data_q;
    assign bus.busy_o     = (|bus.wb_valid_i) | wr_en_q;

    logic [NUM_WB-1:0]                valid_s;
    logic [NUM_WB-1:0]                ready_s;
    logic [NUM_WB-1:0][WB_ADDR_W-1:0] addr_s;

    assign valid_s = bus.wb_valid_i;
    assign ready_s = bus.wb_ready_o;
    assign addr_s  = bus.wb_addr_i;

    a_ready_onehot : assert property (@(posedge clk_i) disable iff (!arst_ni)
        $onehot0(ready_s));

    a_ready_valid : assert property (@(posedge clk_i) disable iff (!arst_ni)
        (ready_s & ~valid_s) == '0);

    // A requester must keep its write offered, unchanged, until it sees ready.
    for (genvar i = 0; i < NUM_WB; i++) begin : g_req_hold
        a_valid_kept : assert property (@(posedge clk_i) disable iff (!arst_ni)
            (valid_s[i] && !ready_s[i]) |=> (valid_s[i] && $stable(addr_s[i])));
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by randomized traffic,
// all compared against a distance-based round-robin reference model.
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int N = 4;

    logic clk_i   = 1'b0;
    logic arst_ni = 1'b0;

    wb_arbiter_if #(.NUM_WB(N), .MAXLEN(64)) bus ();

    wb_arbiter #(.NUM_WB(N), .MAXLEN(64)) dut (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .bus     (bus)
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    wb_req_t     lane [N];
    int          m_ptr   = 0;
    bit          m_wr_en = 1'b0;
    logic [5:0]  m_addr  = '0;
    logic [63:0] m_data  = '0;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner is the valid lane with the smallest forward distance from the pointer.
    function automatic int pickWinner(input logic [N-1:0] v, input logic h, input int p);
        int best  = -1;
        int bestd = N;
        if (h) return -1;
        for (int i = 0; i < N; i++) begin
            if (v[i] && ((i - p + N) % N) < bestd) begin
                best  = i;
                bestd = (i - p + N) % N;
            end
        end
        return best;
    endfunction

    task automatic applyStimulus(input logic [N-1:0] v_in, input logic h_in,
                                 output logic [N-1:0] ready_obs, output int g);
        logic [N-1:0] exp_ready;
        bus.wb_valid_i = v_in;
        bus.hold_i     = h_in;
        for (int i = 0; i < N; i++) begin
            bus.wb_addr_i[i] = lane[i].addr;
            bus.wb_data_i[i] = lane[i].data;
        end
        g         = pickWinner(v_in, h_in, m_ptr);
        exp_ready = (g < 0) ? '0 : N'(1 << g);
        #2;
        ready_obs = bus.wb_ready_o;
        checkOutput("ready", 64'(ready_obs), 64'(exp_ready));
        checkOutput("busy", 64'(bus.busy_o), 64'((|v_in) | m_wr_en));
        @(posedge clk_i);
        #1;
        m_wr_en = (g >= 0);
        if (g >= 0) begin
            m_addr = lane[g].addr;
            m_data = lane[g].data;
            m_ptr  = (g + 1) % N;
        end
        checkOutput("wr_en", 64'(bus.wr_en_o), 64'(m_wr_en));
        checkOutput("wr_addr", 64'(bus.wr_addr_o), 64'(m_addr));
        checkOutput("wr_data", bus.wr_data_o, m_data);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] v;
        int           g;
        logic [N-1:0] exp_r;

        for (int i = 0; i < N; i++) lane[i] = '{addr: '0, data: '0};
        bus.wb_valid_i = '0;
        bus.wb_addr_i  = '0;
        bus.wb_data_i  = '0;
        bus.hold_i     = 1'b0;

        // Reset: outputs cleared and no ready even with a request offered.
        #1;
        bus.wb_valid_i = 4'b0001;
        #1;
        checkOutput("rst_ready", 64'(bus.wb_ready_o), 64'h0);
        checkOutput("rst_wr_en", 64'(bus.wr_en_o), 64'h0);
        checkOutput("rst_wr_addr", 64'(bus.wr_addr_o), 64'h0);
        checkOutput("rst_wr_data", bus.wr_data_o, 64'h0);
        bus.wb_valid_i = '0;
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        arst_ni = 1'b1;

        for (int c = 0; c < 10; c++) begin
            applyStimulus(4'b0000, 1'b0, r, g);
            checkOutput("idle_busy", 64'(bus.busy_o), 64'h0);
        end

        // Single write from the FPU lane.
        lane[WB_FPU] = '{addr: 6'h25, data: 64'hDEAD_BEEF};
        applyStimulus(4'b0100, 1'b0, r, g);
        checkOutput("single_ready", 64'(r), 64'h4);
        checkOutput("single_wr_en", 64'(bus.wr_en_o), 64'h1);
        checkOutput("single_wr_addr", 64'(bus.wr_addr_o), 64'h25);
        checkOutput("single_wr_data", bus.wr_data_o, 64'hDEAD_BEEF);

        // Fairness: pointer now at 3, so grants run 3,0,1,2,...
        for (int i = 0; i < N; i++) lane[i] = '{addr: 6'(6'h10 + i), data: 64'(64'hF000 + i)};
        for (int k = 0; k < 8; k++) begin
            applyStimulus(4'b1111, 1'b0, r, g);
            exp_r = N'(1 << ((3 + k) % N));
            checkOutput("rr_order", 64'(r), 64'(exp_r));
            checkOutput("rr_wr_en", 64'(bus.wr_en_o), 64'h1);
        end
        v = 4'b1111;
        v[g] = 1'b0;
        for (int n = 0; n < 8 && v != '0; n++) begin
            applyStimulus(v, 1'b0, r, g);
            if (g >= 0) v[g] = 1'b0;
        end

        // Same address from lanes 1 and 3 with pointer at 2: lane 3 first, lane 1 last.
        lane[1] = '{addr: 6'h05, data: 64'd1};
        lane[3] = '{addr: 6'h05, data: 64'd3};
        applyStimulus(4'b1010, 1'b0, r, g);
        checkOutput("same_first_ready", 64'(r), 64'h8);
        checkOutput("same_first_data", bus.wr_data_o, 64'd3);
        applyStimulus(4'b0010, 1'b0, r, g);
        checkOutput("same_second_ready", 64'(r), 64'h2);
        checkOutput("same_last_addr", 64'(bus.wr_addr_o), 64'h05);
        checkOutput("same_last_data", bus.wr_data_o, 64'd1);
        applyStimulus(4'b0000, 1'b0, r, g);

        // Hold freezes grants; the lane is served once hold drops.
        lane[WB_ALU] = '{addr: 6'h07, data: 64'd77};
        for (int c = 0; c < 5; c++) begin
            applyStimulus(4'b0001, 1'b1, r, g);
            checkOutput("hold_ready", 64'(r), 64'h0);
            checkOutput("hold_wr_en", 64'(bus.wr_en_o), 64'h0);
        end
        applyStimulus(4'b0001, 1'b0, r, g);
        checkOutput("release_ready", 64'(r), 64'h1);
        checkOutput("release_wr_en", 64'(bus.wr_en_o), 64'h1);
        applyStimulus(4'b0100, 1'b1, r, g);
        applyStimulus(4'b0100, 1'b0, r, g);

        // Reset in the middle of a registered write.
        lane[WB_LSU] = '{addr: 6'h0A, data: 64'hAAAA};
        applyStimulus(4'b0010, 1'b0, r, g);
        checkOutput("midrst_pre_wr_en", 64'(bus.wr_en_o), 64'h1);
        #3;
        arst_ni = 1'b0;
        #1;
        checkOutput("midrst_wr_en", 64'(bus.wr_en_o), 64'h0);
        checkOutput("midrst_wr_addr", 64'(bus.wr_addr_o), 64'h0);
        checkOutput("midrst_ready", 64'(bus.wb_ready_o), 64'h0);
        bus.wb_valid_i = '0;
        m_ptr   = 0;
        m_wr_en = 1'b0;
        m_addr  = '0;
        m_data  = '0;
        @(posedge clk_i);
        #1;
        checkOutput("midrst_edge_wr_en", 64'(bus.wr_en_o), 64'h0);
        arst_ni = 1'b1;

        lane[1] = '{addr: 6'h11, data: 64'h11};
        lane[3] = '{addr: 6'h13, data: 64'h13};
        applyStimulus(4'b1010, 1'b0, r, g);
        checkOutput("postrst_ready", 64'(r), 64'h2);
        applyStimulus(4'b1000, 1'b0, r, g);
        checkOutput("postrst_second", 64'(r), 64'h8);

        // Randomized traffic with random hold.
        v = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!v[i] && ($urandom_range(1, 0) == 1)) begin
                    lane[i].addr = 6'($urandom);
                    lane[i].data = {$urandom, $urandom};
                    v[i] = 1'b1;
                end
            end
            applyStimulus(v, ($urandom_range(4, 0) == 0), r, g);
            if (g >= 0) v[g] = 1'b0;
        end
        for (int n = 0; n < 8 && v != '0; n++) begin
            applyStimulus(v, 1'b0, r, g);
            if (g >= 0) v[g] = 1'b0;
        end
        applyStimulus(4'b0000, 1'b0, r, g);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
